// File: rtl/fetch_unit_if.sv
// fetch_unit_if: memory-port, redirect and decode-side handshake bundle
// for the instruction fetch stage. The master modport is the fetch unit's
// own view; slave is the view of the surrounding core and memory.
interface fetch_unit_if #(
    parameter int XLEN = 32,
    parameter int ILEN = 32
);
    logic            mem_req;
    logic [XLEN-1:0] mem_addr;
    logic            mem_gnt;
    logic            mem_rvalid;
    logic [ILEN-1:0] mem_rdata;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;
    logic            out_valid;
    logic            out_ready;
    logic [ILEN-1:0] out_instr;
    logic [XLEN-1:0] out_pc;
    logic            out_fault;

    modport master (
        output mem_req, mem_addr,
        input  mem_gnt, mem_rvalid, mem_rdata,
        input  redirect_valid, redirect_pc,
        output out_valid, out_instr, out_pc, out_fault,
        input  out_ready
    );

    modport slave (
        input  mem_req, mem_addr,
        output mem_gnt, mem_rvalid, mem_rdata,
        output redirect_valid, redirect_pc,
        input  out_valid, out_instr, out_pc, out_fault,
        output out_ready
    );
endinterface

// File: rtl/fetch_unit.sv
// fetch_unit: pipelined instruction fetch stage. Keeps a fetch PC, issues
// requests on a grant/rvalid memory port with several transactions in
// flight, buffers returned instructions in a PC-tagged FIFO and hands them
// to decode over valid/ready. A redirect flushes the FIFO and squashes the
// responses still in flight.
// Optional feature macro: FETCH_MISALIGN_TRAP_EN -- a misaligned redirect
// target produces a single fault entry and parks the unit in FAULT until
// the next redirect. Without it the target is silently word-aligned.

// Protocol checker: memory must never answer when nothing is in flight.
module fetch_unit_chk #(
    parameter int CW = 3
) (
    input logic          clk,
    input logic          cpu_rstn,
    input logic          mem_rvalid,
    input logic [CW-1:0] outstanding
);
    rvalid_has_request: assert property (
        @(posedge clk) disable iff (!cpu_rstn)
        mem_rvalid |-> (outstanding != {CW{1'b0}})
    );
endmodule

module fetch_unit #(
    parameter int              XLEN       = 32,
    parameter int              ILEN       = 32,
    parameter logic [XLEN-1:0] RESET_PC   = 32'h0000_0000,
    parameter int              FIFO_DEPTH = 4
) (
    input logic          clk,
    input logic          cpu_rstn,
    fetch_unit_if.master bus
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    localparam logic [CW:0]     DEPTH_C    = FIFO_DEPTH[CW:0];
    localparam logic [XLEN-1:0] PC_STEP    = XLEN'(32'd4);
    localparam logic [XLEN-1:0] ALIGN_MASK = ~(XLEN'(32'd3));
    localparam logic [AW-1:0]   PTR_ZERO   = AW'(32'd0);
    localparam logic [AW-1:0]   PTR_ONE    = AW'(32'd1);
    localparam logic [CW-1:0]   CNT_ZERO   = CW'(32'd0);
    localparam logic [CW-1:0]   CNT_ONE    = CW'(32'd1);

    typedef enum logic [0:0] {
        ST_RUN   = 1'b0,
        ST_FAULT = 1'b1
    } state_t;

    state_t          state_r;
    logic [XLEN-1:0] pc_r;
    logic [XLEN-1:0] resp_pc_r;
    logic [CW-1:0]   outstanding_r;
    logic [CW-1:0]   drop_cnt_r;
    logic [CW-1:0]   count_r;
    logic [AW-1:0]   wr_ptr_r;
    logic [AW-1:0]   rd_ptr_r;
    logic [ILEN-1:0] instr_mem_r [FIFO_DEPTH];
    logic [XLEN-1:0] pc_mem_r    [FIFO_DEPTH];
`ifdef FETCH_MISALIGN_TRAP_EN
    logic [FIFO_DEPTH-1:0] fault_mem_r;
`endif

    logic [CW:0]     credit_s;
    logic            req_s;
    logic            gnt_s;
    logic            rvalid_ok_s;
    logic            push_s;
    logic            pop_s;
    logic            out_valid_s;
    logic            misalign_s;
    logic [XLEN-1:0] target_s;
    logic [CW-1:0]   gnt_inc_s;
    logic [CW-1:0]   rvalid_dec_s;
    logic [CW-1:0]   push_inc_s;
    logic [CW-1:0]   pop_dec_s;

    // Request credit, response acceptance and FIFO handshake decode.
    always_comb begin
        credit_s    = {1'b0, outstanding_r} + {1'b0, count_r};
        out_valid_s = (count_r != CNT_ZERO);
        target_s    = bus.redirect_pc & ALIGN_MASK;
`ifdef FETCH_MISALIGN_TRAP_EN
        misalign_s  = (bus.redirect_pc[1:0] != 2'b00);
`else
        misalign_s  = 1'b0;
`endif
        // Every in-flight request plus every buffered entry holds a slot,
        // so a response can always be pushed without back-pressure.
        if (cpu_rstn && (state_r == ST_RUN) && !bus.redirect_valid && (credit_s < DEPTH_C)) begin
            req_s = 1'b1;
        end else begin
            req_s = 1'b0;
        end
        gnt_s        = req_s && bus.mem_gnt;
        rvalid_ok_s  = bus.mem_rvalid && (outstanding_r != CNT_ZERO);
        push_s       = rvalid_ok_s && (drop_cnt_r == CNT_ZERO) && !bus.redirect_valid
                       && (state_r == ST_RUN);
        pop_s        = out_valid_s && bus.out_ready;
        gnt_inc_s    = {{(CW-1){1'b0}}, gnt_s};
        rvalid_dec_s = {{(CW-1){1'b0}}, rvalid_ok_s};
        push_inc_s   = {{(CW-1){1'b0}}, push_s};
        pop_dec_s    = {{(CW-1){1'b0}}, pop_s};
    end

    assign bus.mem_req   = req_s;
    assign bus.mem_addr  = pc_r;
    assign bus.out_valid = out_valid_s;
    assign bus.out_instr = out_valid_s ? instr_mem_r[rd_ptr_r] : {ILEN{1'b0}};
    assign bus.out_pc    = out_valid_s ? pc_mem_r[rd_ptr_r] : {XLEN{1'b0}};
`ifdef FETCH_MISALIGN_TRAP_EN
    assign bus.out_fault = out_valid_s & fault_mem_r[rd_ptr_r];
`else
    assign bus.out_fault = 1'b0;
`endif

    // Fetch PC, credit/drop counters, FIFO pointers and RUN/FAULT state.
    always_ff @(posedge clk or negedge cpu_rstn) begin
        if (!cpu_rstn) begin
            state_r       <= ST_RUN;
            pc_r          <= RESET_PC;
            resp_pc_r     <= RESET_PC;
            outstanding_r <= CNT_ZERO;
            drop_cnt_r    <= CNT_ZERO;
            count_r       <= CNT_ZERO;
            wr_ptr_r      <= PTR_ZERO;
            rd_ptr_r      <= PTR_ZERO;
        end else if (bus.redirect_valid) begin
            // Everything still in flight (minus a response landing now)
            // belongs to the old stream and must be discarded on return.
            pc_r          <= target_s;
            resp_pc_r     <= target_s;
            outstanding_r <= outstanding_r - rvalid_dec_s;
            drop_cnt_r    <= outstanding_r - rvalid_dec_s;
            rd_ptr_r      <= PTR_ZERO;
            if (misalign_s) begin
                wr_ptr_r <= PTR_ONE;
                count_r  <= CNT_ONE;
                state_r  <= ST_FAULT;
            end else begin
                wr_ptr_r <= PTR_ZERO;
                count_r  <= CNT_ZERO;
                state_r  <= ST_RUN;
            end
        end else begin
            if (gnt_s) begin
                pc_r <= pc_r + PC_STEP;
            end
            outstanding_r <= outstanding_r + gnt_inc_s - rvalid_dec_s;
            if (rvalid_ok_s && (drop_cnt_r != CNT_ZERO)) begin
                drop_cnt_r <= drop_cnt_r - CNT_ONE;
            end
            if (push_s) begin
                resp_pc_r <= resp_pc_r + PC_STEP;
                wr_ptr_r  <= wr_ptr_r + PTR_ONE;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            count_r <= count_r + push_inc_s - pop_dec_s;
        end
    end

    // FIFO storage: a misaligned redirect writes its fault entry into slot 0,
    // otherwise an accepted response is written at the tail.
    always_ff @(posedge clk or negedge cpu_rstn) begin
        if (!cpu_rstn) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                instr_mem_r[i] <= {ILEN{1'b0}};
                pc_mem_r[i]    <= {XLEN{1'b0}};
            end
`ifdef FETCH_MISALIGN_TRAP_EN
            fault_mem_r <= {FIFO_DEPTH{1'b0}};
`endif
        end else if (bus.redirect_valid && misalign_s) begin
            instr_mem_r[PTR_ZERO] <= {ILEN{1'b0}};
            pc_mem_r[PTR_ZERO]    <= bus.redirect_pc;
`ifdef FETCH_MISALIGN_TRAP_EN
            fault_mem_r[PTR_ZERO] <= 1'b1;
`endif
        end else if (push_s) begin
            instr_mem_r[wr_ptr_r] <= bus.mem_rdata;
            pc_mem_r[wr_ptr_r]    <= resp_pc_r;
`ifdef FETCH_MISALIGN_TRAP_EN
            fault_mem_r[wr_ptr_r] <= 1'b0;
`endif
        end
    end

    fetch_unit_chk #(.CW(CW)) u_chk (
        .clk        (clk),
        .cpu_rstn   (cpu_rstn),
        .mem_rvalid (bus.mem_rvalid),
        .outstanding(outstanding_r)
    );
endmodule
